// File: rtl/alu_share_ctrl.sv
// Round-robin front end that time-shares one combinational ALU between
// two requesters and returns each result tagged with its owner.
module alu_share_ctrl #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state_q;
  logic           last_q;
  logic           id_q;
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [1:0]     alu_op_q;
  logic           rsp_valid_q;
  logic [W-1:0]   rsp_data_q;
  logic           rsp_id_q;

  logic idle;
  logic gnt0;
  logic gnt1;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    idle = (state_q == IDLE);
    gnt0 = idle && req0_valid &&
           (!req1_valid || last_q);
    gnt1 = idle && req1_valid &&
           (!req0_valid || !last_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            alu_a_q  <= gnt1 ? req1_a  : req0_a;
            alu_b_q  <= gnt1 ? req1_b  : req0_b;
            alu_op_q <= gnt1 ? req1_op : req0_op;
            id_q     <= gnt1;
            last_q   <= gnt1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model
// of the shared ALU hanging off the alu_* bus.
module tb_alu_share_ctrl;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]   alu_op;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Shared ALU model
  always_comb begin
    int ia, ib, t;
    ia = int'($signed(alu_a));
    ib = int'($signed(alu_b));
    case (alu_op)
      2'b00:   t = ia * 4 + (ib >>> 1);
      2'b01:   t = ia + 3 * ib;
      2'b10:   t = -ib;
      default: begin
        t = 2 * ia - ib;
        if (t < 0) t = -t;
      end
    endcase
    alu_y = t[W-1:0];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  // Single-requester transaction with rsp_ready held high.
  task automatic txn(input bit n, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [1:0] op,
                     input logic [W-1:0] exp, input string tag);
    if (n) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk({tag, "_ready"}, n ? req1_ready : req0_ready, 1);
    chk({tag, "_other_rdy"}, n ? req0_ready : req1_ready, 0);
    nxt();
    req0_valid = 0; req1_valid = 0;
    req0_a = '1; req1_a = '1; req0_b = '1; req1_b = '1;
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_exec_v"}, rsp_valid, 0);
    chk({tag, "_exec_busy"}, busy, 1);
    nxt();
    chk({tag, "_v"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_id"}, rsp_id, n);
    nxt();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [1:0]   ids  [4];
    logic [W-1:0] dats [4];
    int got;
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    nxt(); nxt();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    rst = 0;
    nxt();

    // T1, T3, T2 ordered so the last grant before T4 is requester 1
    txn(0, 6'd3, 6'd4, 2'b00, 6'd14, "t1");
    txn(0, 6'd2, 6'd5, 2'b11, 6'd1, "t3abs");
    txn(0, 6'h20, 6'd0, 2'b01, 6'h20, "t3wrap");
    txn(0, 6'd0, 6'd5, 2'b10, 6'h3B, "t2neg");
    txn(1, 6'd1, 6'd2, 2'b01, 6'd7, "t2r1");

    // T4: both valid continuously
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 2'b01;
    req1_valid = 1; req1_a = 2; req1_b = 0; req1_op = 2'b10;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      #1;
      if (req0_ready && req1_ready)
        chk("t4_dual_ready", 1, 0);
      nxt();
      if (rsp_valid) begin
        ids[got]  = {1'b0, rsp_id};
        dats[got] = rsp_data;
        got++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("t4_count", got, 4);
    chk("t4_ids", {ids[0], ids[1], ids[2], ids[3]},
        {2'd0, 2'd1, 2'd0, 2'd1});
    chk("t4_data", {dats[0], dats[1], dats[2], dats[3]},
        {6'd4, 6'd0, 6'd4, 6'd0});
    nxt();
    chk("t4_idle", busy, 0);

    // T5: back-pressure in RESP
    rsp_ready = 0;
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 2'b00;
    nxt();
    nxt();
    chk("t5_v", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("t5_hold", {rsp_valid, rsp_id, rsp_data, busy,
                      req0_ready}, {1'b1, 1'b0, 6'd14, 1'b1, 1'b0});
    end
    req0_valid = 0;
    rsp_ready = 1;
    nxt();
    chk("t5_release", {rsp_valid, busy}, 2'b00);

    // T6: reset during EXEC
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 2'b11;
    nxt();
    req0_valid = 0;
    chk("t6_exec", busy, 1);
    rst = 1;
    nxt();
    chk("t6_flush", {rsp_valid, busy, rsp_id, rsp_data,
                     alu_a, alu_b, alu_op}, 0);
    rst = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 2'b01;
    req1_valid = 1; req1_a = 3; req1_b = 3; req1_op = 2'b00;
    #1;
    chk("t6_tie", {req0_ready, req1_ready}, 2'b10);
    nxt();
    req0_valid = 0; req1_valid = 0;
    nxt();
    chk("t6_rsp", {rsp_valid, rsp_id, rsp_data},
        {1'b1, 1'b0, 6'd7});
    nxt();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
